// File: rtl/neopixel_frame_driver_if.sv
// Pixel-buffer write port and frame handshake between game logic and the
// WS2812 frame driver.
//   pixel_we/pixel_addr/pixel_grb : buffer write (colour is {G,R,B})
//   send                          : level-sampled frame request
//   busy/done                     : frame-in-progress level, completion pulse
// master = game logic, slave = frame driver.
interface neopixel_frame_driver_if #(
  parameter int NUM_PIXELS = 8,
  parameter int AW         = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
);
  logic          pixel_we;
  logic [AW-1:0] pixel_addr;
  logic [23:0]   pixel_grb;
  logic          send;
  logic          busy;
  logic          done;

  modport master (
    output pixel_we, pixel_addr, pixel_grb, send,
    input  busy, done
  );

  modport slave (
    input  pixel_we, pixel_addr, pixel_grb, send,
    output busy, done
  );
endinterface

// File: rtl/neopixel_frame_driver.sv
// WS2812 frame serializer. Holds NUM_PIXELS GRB colours and, on send,
// shifts them out MSB first, pixel 0 first, as fixed-period high/low bit
// cells, followed by a low latch gap.
//   clock    : system clock (50 MHz nominal)
//   reset    : asynchronous, active low; clears buffer and FSM
//   bus      : slave side of neopixel_frame_driver_if
//   neo_data : registered serial line to the strip
module neopixel_frame_driver #(
  parameter int NUM_PIXELS   = 8,
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int BIT_CYCLES   = 63,
  parameter int LATCH_CYCLES = 3000
) (
  input  logic                     clock,
  input  logic                     reset,
  neopixel_frame_driver_if.slave   bus,
  output logic                     neo_data
);

  localparam int PW   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int MAXC = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] T0H_LAST   = CW'(T0H_CYCLES - 1);
  localparam logic [CW-1:0] T1H_LAST   = CW'(T1H_CYCLES - 1);
  localparam logic [PW-1:0] PIX_LAST   = PW'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_LATCH} state_t;

  state_t                         state, state_nx;
  logic [CW-1:0]                  cnt;
  logic [4:0]                     bit_idx;
  logic [PW-1:0]                  pix_idx;
  logic [NUM_PIXELS-1:0][23:0]    buf_q;

  logic          cur_bit;
  logic [CW-1:0] hi_last;
  logic          last_bit, last_pix;
  logic          neo_nx, busy_nx, done_nx;

  assign cur_bit  = buf_q[pix_idx][bit_idx];
  assign hi_last  = cur_bit ? T1H_LAST : T0H_LAST;
  assign last_bit = (bit_idx == 5'd0);
  assign last_pix = (pix_idx == PIX_LAST);

  // Buffer is only writable between frames so a frame never mixes colours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_q <= '0;
    end else if (state == S_IDLE && bus.pixel_we &&
                 32'(bus.pixel_addr) < 32'(NUM_PIXELS)) begin
      buf_q[bus.pixel_addr] <= bus.pixel_grb;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.send) state_nx = S_HIGH;
      S_HIGH:  if (cnt == hi_last) state_nx = S_LOW;
      S_LOW:   if (cnt == BIT_LAST) state_nx = (last_bit && last_pix) ? S_LATCH : S_HIGH;
      S_LATCH: if (cnt == LATCH_LAST) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // One counter spans HIGH and LOW of a bit cell, so the cell length is
  // BIT_CYCLES regardless of where the high/low split falls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      pix_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          pix_idx <= '0;
          bit_idx <= bus.send ? 5'd23 : 5'd0;
        end
        S_HIGH: cnt <= cnt + 1'b1;
        S_LOW: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (last_bit) begin
              bit_idx <= 5'd23;
              if (!last_pix) pix_idx <= pix_idx + 1'b1;
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LATCH: cnt <= cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs decoded from the next state and registered, so the line is
  // glitch-free and done lands on the first IDLE cycle.
  always_comb begin
    neo_nx  = (state_nx == S_HIGH);
    busy_nx = (state_nx != S_IDLE);
    done_nx = (state == S_LATCH) && (state_nx == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      neo_data <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      neo_data <= neo_nx;
      bus.busy <= busy_nx;
      bus.done <= done_nx;
    end
  end

endmodule

// File: tb/tb_neopixel_frame_driver.sv
// Bench for neopixel_frame_driver with a 2-pixel strip. Expected bits and
// frame words are queued when a frame is requested; a negedge monitor
// measures pulse widths, bit periods, busy length and done and pops them.
module tb_neopixel_frame_driver;

  localparam int NP    = 2;
  localparam int T0H   = 20;
  localparam int T1H   = 40;
  localparam int BITC  = 63;
  localparam int LATCH = 3000;
  localparam int FW    = NP * 24;
  localparam int FRAME = NP * 24 * BITC + LATCH;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic neo_data;

  neopixel_frame_driver_if #(.NUM_PIXELS(NP)) bus ();

  neopixel_frame_driver #(
    .NUM_PIXELS(NP), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
    .BIT_CYCLES(BITC), .LATCH_CYCLES(LATCH)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .neo_data(neo_data)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // scoreboard
  logic [23:0]   mdl [NP];
  bit            bit_q[$];
  logic [FW-1:0] frame_q[$];

  task automatic push_frame();
    logic [FW-1:0] w;
    w = '0;
    for (int p = 0; p < NP; p++) begin
      for (int b = 23; b >= 0; b--) bit_q.push_back(mdl[p][b]);
      w = {w[FW-25:0], mdl[p]};
    end
    frame_q.push_back(w);
  endtask

  // monitor
  int            hi_w, lo_w, per, busy_len, done_w, fbits, last_gap;
  logic          prev_neo, prev_busy;
  logic [FW-1:0] dec;
  bit            eb;

  always @(negedge clock) begin
    if (!reset) begin
      prev_neo = 1'b0; prev_busy = 1'b0;
      hi_w = 0; lo_w = 0; per = 0; busy_len = 0; done_w = 0; fbits = 0;
      dec = '0;
    end else begin
      if (neo_data) begin
        if (!prev_neo) begin
          if (fbits > 0) chk("bit_period", per, BITC);
          last_gap = lo_w;
          lo_w = 0; per = 0; hi_w = 0;
        end
        hi_w++;
      end else begin
        if (prev_neo) begin
          if (bit_q.size() == 0) chk("bit_unexpected", 1, 0);
          else begin
            eb = bit_q.pop_front();
            chk("bit_high", hi_w, eb ? T1H : T0H);
          end
          dec = {dec[FW-2:0], (hi_w > (T0H + T1H) / 2)};
          fbits++;
        end
        lo_w++;
      end
      per++;

      if (bus.busy) busy_len++;
      else if (prev_busy) begin
        chk("busy_len", busy_len, FRAME);
        chk("done_at_end", bus.done, 1);
        if (frame_q.size() == 0) chk("frame_unexpected", 1, 0);
        else chk("frame_word", dec, frame_q.pop_front());
        busy_len = 0; fbits = 0; dec = '0;
      end

      if (bus.done) done_w++;
      else if (done_w > 0) begin
        chk("done_width", done_w, 1);
        done_w = 0;
      end

      prev_neo  = neo_data;
      prev_busy = bus.busy;
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.done !== 1'b1 && n < budget);
    if (bus.done !== 1'b1) chk("timeout_done", 0, 1);
  endtask

  task automatic pulse_send();
    @(negedge clock);
    bus.send = 1'b1;
    push_frame();
    @(negedge clock);
    bus.send = 1'b0;
  endtask

  task automatic write_px(input int a, input logic [23:0] d);
    @(negedge clock);
    bus.pixel_we   = 1'b1;
    bus.pixel_addr = a[0:0];
    bus.pixel_grb  = d;
    @(negedge clock);
    bus.pixel_we   = 1'b0;
  endtask

  initial begin
    bus.pixel_we = 1'b0; bus.pixel_addr = '0; bus.pixel_grb = '0; bus.send = 1'b1;
    for (int p = 0; p < NP; p++) mdl[p] = '0;

    // 1: reset with send held
    repeat (3) @(negedge clock);
    chk("rst_neo", neo_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    push_frame();
    #2 reset = 1'b1;
    @(negedge clock);
    chk("t1_start_neo", neo_data, 1);
    chk("t1_start_busy", bus.busy, 1);
    bus.send = 1'b0;
    wait_done(FRAME + 100);

    // 2: mixed pattern
    write_px(0, 24'h800001); mdl[0] = 24'h800001;
    write_px(1, 24'hFFFFFF); mdl[1] = 24'hFFFFFF;
    pulse_send();
    wait_done(FRAME + 100);

    // 3: send and write mid-frame are ignored
    pulse_send();
    repeat (300) @(negedge clock);
    bus.send = 1'b1; bus.pixel_we = 1'b1; bus.pixel_addr = '0; bus.pixel_grb = 24'h00FF00;
    @(negedge clock);
    bus.send = 1'b0; bus.pixel_we = 1'b0;
    wait_done(FRAME + 100);
    repeat (5) @(negedge clock);
    chk("t3_no_restart", bus.busy, 0);
    pulse_send();
    wait_done(FRAME + 100);

    // 4: send in the done cycle
    bus.send = 1'b1;
    push_frame();
    @(negedge clock);
    chk("t4_b2b_start", neo_data, 1);
    bus.send = 1'b0;
    @(negedge clock);
    chk("t4_b2b_gap", (last_gap >= LATCH), 1);
    wait_done(FRAME + 100);

    // 5: reset mid-frame clears everything
    pulse_send();
    repeat (500) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("t5_neo", neo_data, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_done", bus.done, 0);
    bit_q.delete();
    frame_q.delete();
    for (int p = 0; p < NP; p++) mdl[p] = '0;
    @(negedge clock);
    #2 reset = 1'b1;
    pulse_send();
    wait_done(FRAME + 100);

    // 6: same-cycle write and send
    @(negedge clock);
    bus.pixel_we = 1'b1; bus.pixel_addr = 1'b1; bus.pixel_grb = 24'h123456; bus.send = 1'b1;
    mdl[1] = 24'h123456;
    push_frame();
    @(negedge clock);
    bus.pixel_we = 1'b0; bus.send = 1'b0;
    wait_done(FRAME + 100);
    repeat (3) @(negedge clock);
    chk("sb_bits_empty", bit_q.size(), 0);
    chk("sb_frames_empty", frame_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
